// File: rtl/mandel_pkg.sv
// Shared types and helpers for the Mandelbrot pixel packer.
package mandel_pkg;

    // FIFO entry: {sof, eof, data[7:0]}
    localparam int unsigned ENTRY_W = 10;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitStart,
        StWaitDone,
        StDrain
    } packer_state_t;

    function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    // Index width that never collapses to zero for tiny frames
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mandel_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and full/empty flags.
// Head reads as zero while the FIFO is empty.
module mandel_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/mandel_pixel_packer.sv
// Paces the iteration engine one pixel at a time, packs two 4-bit results per
// byte and streams them with sof/eof tags through a small FIFO.
// Optional feature: define MANDEL_PACKER_STALL_CNT_EN to build the stall counter.
module mandel_pixel_packer
    import mandel_pkg::*;
#(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        pix_running,
    input  logic [3:0]  pix_ctr,
    output logic        pix_run,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] stall_cycles
);
    localparam int unsigned NPIX  = frame_pixels(WIDTH, HEIGHT);
    localparam int unsigned IDX_W = idx_width(NPIX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    packer_state_t        state_q;
    logic [IDX_W-1:0]     pix_idx_q;
    logic                 half_q;
    logic [3:0]           hold_q;
    logic                 l_running_q;
    logic                 pix_run_q;
    logic                 frame_done_q;

    logic                 complete, is_last, push, pop;
    logic [ENTRY_W-1:0]   push_entry, head;
    logic [7:0]           push_byte;
    logic                 fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    assign complete  = (state_q == StWaitDone) && l_running_q && !pix_running;
    assign is_last   = (pix_idx_q == LAST_IDX);
    assign push      = complete && (half_q || is_last);
    // A lone last pixel lands in the high nibble with a zero pad
    assign push_byte = half_q ? {hold_q, pix_ctr} : {pix_ctr, 4'h0};
    // Byte holds pixel 0 when it covers pixel pair index 0
    assign push_entry = {((pix_idx_q >> 1) == '0), is_last, push_byte};
    assign pop       = out_valid && out_ready;

    mandel_sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Delayed engine running flag for falling-edge completion detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) l_running_q <= 1'b0;
        else        l_running_q <= pix_running;
    end

    // Frame sequencing FSM with registered run and done pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pix_idx_q    <= '0;
            half_q       <= 1'b0;
            hold_q       <= 4'h0;
            pix_run_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pix_run_q    <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        pix_idx_q <= '0;
                        half_q    <= 1'b0;
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    if (!fifo_full && !pix_running) begin
                        pix_run_q <= 1'b1;
                        state_q   <= StWaitStart;
                    end
                end
                StWaitStart: begin
                    if (pix_running) state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (complete) begin
                        if (!half_q && !is_last) begin
                            hold_q <= pix_ctr;
                            half_q <= 1'b1;
                        end else begin
                            half_q <= 1'b0;
                        end
                        pix_idx_q <= pix_idx_q + 1'b1;
                        state_q   <= is_last ? StDrain : StIssue;
                    end
                end
                StDrain: begin
                    if (fifo_count == '0) begin
                        frame_done_q <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MANDEL_PACKER_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of issue cycles blocked by a full FIFO, cleared per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
        end else if (state_q == StIdle && enable) begin
            stall_q <= 16'h0000;
        end else if (state_q == StIssue && fifo_full && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0000;
`endif

    assign pix_run    = pix_run_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != StIdle);
    assign out_valid  = !fifo_empty;
    assign out_sof    = head[9];
    assign out_eof    = head[8];
    assign out_data   = head[7:0];

endmodule

// File: doc/mandel_pixel_packer.md
# mandel_pixel_packer

Downstream consumer of the Mandelbrot iteration engine. Paces the engine one pixel at a time with `run` pulses, captures each 4-bit iteration value when the engine stops, and packs two pixels per byte. Bytes are buffered in a small FIFO and offered on a valid/ready stream with start-of-frame and end-of-frame tags. When the FIFO is full the engine is held stopped, so downstream backpressure throttles pixel generation.

## Interface
Parameters:
- `WIDTH`, 320, pixels per line (must match engine)
- `HEIGHT`, 240, lines per frame (must match engine)
- `DEPTH`, 8, FIFO depth in entries, power of two, ≥ 2

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `enable`  in  1  start a frame; sampled only in IDLE
- `pix_running`  in  1  engine `running`
- `pix_ctr`  in  4  engine `ctr_out`
- `pix_run`  out  1  one-cycle start pulse to engine `run`
- `out_data`  out  8  packed byte: even pixel in [7:4], odd pixel in [3:0]
- `out_sof`  out  1  tag: byte holds frame pixel 0
- `out_eof`  out  1  tag: byte holds last frame pixel
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head
- `busy`  out  1  frame in progress (state ≠ IDLE)
- `frame_done`  out  1  one-cycle pulse after last byte popped
- `stall_cycles`  out  16  blocked-issue cycle count (see Configuration)

## Operation
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, DRAIN.
- IDLE: `enable`=1 → clear `pix_idx`, `half`, and the stall counter; go to ISSUE.
- ISSUE: if FIFO is not full and `pix_running`=0 → assert `pix_run` for one cycle and go to WAIT_START. Otherwise hold with `pix_run`=0.
- WAIT_START: `pix_running`=1 → WAIT_DONE.
- WAIT_DONE: completion is `l_running`=1 and `pix_running`=0, where `l_running` is `pix_running` registered. On completion, capture `pix_ctr`:
  - `half`=0: store the value in `hold[7:4]`, set `half`=1.
  - `half`=1: push {`hold[7:4]`, `pix_ctr`} with tags, clear `half`.
  - Last pixel (`pix_idx` = WIDTH·HEIGHT−1) with `half`=0: push {`pix_ctr`, 4'h0}; the odd-count pad is zero.
  - Then increment `pix_idx`. Go to DRAIN if this was the last pixel, else ISSUE.
- Tags: `sof`=1 on the byte containing pixel 0. `eof`=1 on the byte containing the last pixel. Both are stored in the FIFO alongside the data, so the FIFO is 10 bits wide.
- DRAIN: FIFO empty → pulse `frame_done`, go to IDLE.
- `enable` is ignored outside IDLE. A deassert mid-frame does not abort the frame.
- Stream: `out_valid` = FIFO not empty. A pop occurs when `out_valid` and `out_ready` are both high. `out_data`/`out_sof`/`out_eof` hold steady while `out_valid`=1 and `out_ready`=0.
- Simultaneous push and pop: the FIFO count is unchanged and both take effect. A push into a full FIFO cannot occur, because ISSUE is gated on not-full and each issued pixel causes at most one push.
- `pix_idx` width is $clog2(WIDTH·HEIGHT).

## Timing
- Reset values: state IDLE, `pix_run`=0, `out_valid`=0, `out_data`/`out_sof`/`out_eof`=0 (empty-FIFO head), `busy`=0, `frame_done`=0, `stall_cycles`=0, `l_running`=0, FIFO empty.
- `pix_run` is registered and issued the cycle after ISSUE is entered with space available. The engine raises `running` one cycle after `pix_run`.
- Completion is detected one cycle after `running` falls. The push happens on that edge, and `out_valid` rises on the next cycle.
- Minimum issue-to-issue spacing is engine latency + 3 cycles.
- Reset mid-frame: all state is cleared immediately and the FIFO is emptied. The engine is reset by the same `rst_n`.

## Configuration
- `MANDEL_PACKER_STALL_CNT_EN` defined: `stall_cycles` increments, saturating at 16'hFFFF, on every ISSUE cycle blocked by a full FIFO. It is cleared when a frame starts.
- Not defined: `stall_cycles` is tied to 0 and no counter logic is built.

## Structure
- `mandel_pkg` holds:
  - the state enum `packer_state_t`
  - `FRAME_PIXELS` = WIDTH·HEIGHT as a function/localparam helper
  - the FIFO entry width constant (10)
- Sub-module `mandel_sync_fifo` (parameters DEPTH and data width): a single-clock FIFO with count, full/empty flags, and show-ahead head output.

## Test plan
- Single frame, WIDTH=4, HEIGHT=2, behavioural engine returning ctr = pixel index, `out_ready`=1 → 4 bytes 0x01, 0x23, 0x45, 0x67. `sof` is set on byte 0 only, `eof` on byte 3 only. `frame_done` pulses once.
- Odd frame, WIDTH=3, HEIGHT=1, ctr values 0xA, 0xB, 0xC → bytes 0xAB, 0xC0 (eof); the pad nibble is 0.
- Backpressure, DEPTH=2, `out_ready`=0 → after 4 pixels `pix_run` stays low and the FIFO holds 2 entries. Raising `out_ready` resumes issue with no lost or duplicated bytes.
- Simultaneous push/pop at full-minus-one → count is steady and data order is preserved.
- Reset asserted in WAIT_DONE → next cycle `busy`=0 and `out_valid`=0. A new `enable` restarts at pixel 0 with `sof` set.
- Macro defined, `out_ready`=0 for 10 cycles after the FIFO fills → `stall_cycles`=10. Macro undefined → `stall_cycles`=0.
